// File: rtl/order_unloader.sv
// Ping-pong output buffer for the ordering datapath: captures a whole ordered
// frame per handshake and streams it out word by word in forward or reverse order.
module order_unloader #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned DATA_CNT   = 1024,
    parameter string       OUT_ORDER  = "FWD",
    localparam int unsigned IDX_W     = $clog2(DATA_CNT)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [DATA_CNT*DATA_WIDTH-1:0] sort_data,
    input  logic                           sort_valid,
    output logic                           sort_ready,
    output logic [DATA_WIDTH-1:0]          m_data,
    output logic [IDX_W-1:0]               m_idx,
    output logic                           m_valid,
    input  logic                           m_ready,
    output logic                           m_last,
    output logic                           busy,
    output logic                           overflow
);

    localparam bit               REV      = (OUT_ORDER == "REV");
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_CNT - 1);

    logic [DATA_WIDTH-1:0] r_bank [2][DATA_CNT];
    logic [1:0]            r_full;
    logic                  r_wr_sel;
    logic                  r_rd_sel;
    logic [IDX_W-1:0]      r_cnt;
    logic                  r_overflow;

    logic [1:0]            w_full_nxt;
    logic                  w_wr_sel_nxt;
    logic                  w_rd_sel_nxt;
    logic [IDX_W-1:0]      w_cnt_nxt;
    logic                  w_overflow_nxt;
    logic                  w_capture;
    logic                  w_xfer;

    // Control state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_full     <= '0;
            r_wr_sel   <= 1'b0;
            r_rd_sel   <= 1'b0;
            r_cnt      <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_full     <= w_full_nxt;
            r_wr_sel   <= w_wr_sel_nxt;
            r_rd_sel   <= w_rd_sel_nxt;
            r_cnt      <= w_cnt_nxt;
            r_overflow <= w_overflow_nxt;
        end
    end

    // Frame storage; a bank is only written while it is empty
    always_ff @(posedge clk) begin
        if (w_capture) begin
            for (int i = 0; i < int'(DATA_CNT); i++) begin
                r_bank[r_wr_sel][i] <= sort_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Next-state: capture and drain always target different banks, so both may fire together
    always_comb begin
        w_full_nxt     = r_full;
        w_wr_sel_nxt   = r_wr_sel;
        w_rd_sel_nxt   = r_rd_sel;
        w_cnt_nxt      = r_cnt;
        w_overflow_nxt = r_overflow | (sort_valid & ~sort_ready);
        w_capture      = sort_valid & sort_ready;
        w_xfer         = m_valid & m_ready;

        if (w_xfer) begin
            if (m_last) begin
                w_cnt_nxt            = '0;
                w_full_nxt[r_rd_sel] = 1'b0;
                w_rd_sel_nxt         = ~r_rd_sel;
            end else begin
                w_cnt_nxt = r_cnt + IDX_W'(1);
            end
        end

        if (w_capture) begin
            w_full_nxt[r_wr_sel] = 1'b1;
            w_wr_sel_nxt         = ~r_wr_sel;
        end
    end

    // Outputs depend only on registered state, never on m_ready or sort_valid
    always_comb begin
        sort_ready = ~r_full[r_wr_sel];
        m_valid    = r_full[r_rd_sel];
        m_idx      = REV ? (LAST_IDX - r_cnt) : r_cnt;
        m_data     = r_bank[r_rd_sel][m_idx];
        m_last     = m_valid & (r_cnt == LAST_IDX);
        busy       = |r_full;
        overflow   = r_overflow;
    end

endmodule

// File: tb/tb_order_unloader.sv
// Self-checking bench for order_unloader: FWD and REV instances share stimulus
// and are compared every cycle against a frame-queue reference model.
module tb_order_unloader;

    localparam int unsigned DW = 8;
    localparam int unsigned DC = 4;
    localparam int unsigned IW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            sort_valid;
    logic            m_ready;
    logic [DC*DW-1:0] sort_data;

    logic f_sort_ready, f_m_valid, f_m_last, f_busy, f_overflow;
    logic [DW-1:0] f_m_data;
    logic [IW-1:0] f_m_idx;
    logic r_sort_ready, r_m_valid, r_m_last, r_busy, r_overflow;
    logic [DW-1:0] r_m_data;
    logic [IW-1:0] r_m_idx;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // Reference model: queue of pending frames, position within the head frame
    logic [DC*DW-1:0] mq[$];
    int unsigned      m_pos = 0;
    bit               m_ovf = 1'b0;

    always #5 clk = ~clk;

    order_unloader #(.DATA_WIDTH(DW), .DATA_CNT(DC), .OUT_ORDER("FWD")) u_fwd (
        .clk(clk), .rst(rst), .sort_data(sort_data), .sort_valid(sort_valid),
        .sort_ready(f_sort_ready), .m_data(f_m_data), .m_idx(f_m_idx),
        .m_valid(f_m_valid), .m_ready(m_ready), .m_last(f_m_last),
        .busy(f_busy), .overflow(f_overflow)
    );

    order_unloader #(.DATA_WIDTH(DW), .DATA_CNT(DC), .OUT_ORDER("REV")) u_rev (
        .clk(clk), .rst(rst), .sort_data(sort_data), .sort_valid(sort_valid),
        .sort_ready(r_sort_ready), .m_data(r_m_data), .m_idx(r_m_idx),
        .m_valid(r_m_valid), .m_ready(m_ready), .m_last(r_m_last),
        .busy(r_busy), .overflow(r_overflow)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        logic [DC*DW-1:0] fr;
        int unsigned      fi;
        int unsigned      ri;
        bit               v;
        v  = (mq.size() > 0);
        fi = m_pos;
        ri = DC - 1 - m_pos;
        fr = v ? mq[0] : '0;
        check("f_sort_ready", 32'(f_sort_ready), 32'(mq.size() < 2));
        check("r_sort_ready", 32'(r_sort_ready), 32'(mq.size() < 2));
        check("f_m_valid",    32'(f_m_valid),    32'(v));
        check("r_m_valid",    32'(r_m_valid),    32'(v));
        check("f_busy",       32'(f_busy),       32'(v));
        check("r_busy",       32'(r_busy),       32'(v));
        check("f_overflow",   32'(f_overflow),   32'(m_ovf));
        check("r_overflow",   32'(r_overflow),   32'(m_ovf));
        check("f_m_last",     32'(f_m_last),     32'(v && m_pos == DC - 1));
        check("r_m_last",     32'(r_m_last),     32'(v && m_pos == DC - 1));
        check("f_m_idx",      32'(f_m_idx),      fi);
        check("r_m_idx",      32'(r_m_idx),      ri);
        if (v) begin
            check("f_m_data", 32'(f_m_data), 32'(fr[fi*DW +: DW]));
            check("r_m_data", 32'(r_m_data), 32'(fr[ri*DW +: DW]));
        end
    endtask

    task automatic model_step();
        bit rdy;
        bit xf;
        if (rst) begin
            mq.delete();
            m_pos = 0;
            m_ovf = 1'b0;
        end else begin
            rdy = (mq.size() < 2);
            xf  = (mq.size() > 0) && m_ready;
            if (sort_valid && !rdy) m_ovf = 1'b1;
            if (xf) begin
                if (m_pos == DC - 1) begin
                    void'(mq.pop_front());
                    m_pos = 0;
                end else begin
                    m_pos++;
                end
            end
            if (sort_valid && rdy) mq.push_back(sort_data);
        end
    endtask

    task automatic cycle(input bit r, input bit sv, input logic [DC*DW-1:0] d, input bit mr);
        rst        = r;
        sort_valid = sv;
        sort_data  = d;
        m_ready    = mr;
        #2;
        check_outputs();
        @(posedge clk);
        model_step();
        #1;
    endtask

    localparam logic [DC*DW-1:0] FA = 32'h4433_2211;
    localparam logic [DC*DW-1:0] FB = 32'h8877_6655;
    localparam logic [DC*DW-1:0] FC = 32'hCCBB_AA99;

    initial begin
        rst        = 1'b1;
        sort_valid = 1'b0;
        m_ready    = 1'b0;
        sort_data  = '0;
        repeat (2) @(posedge clk);
        #1;

        // Idle after reset
        repeat (4) cycle(1'b0, 1'b0, '0, 1'b0);

        // Single frame, consumer always ready
        cycle(1'b0, 1'b1, FA, 1'b1);
        repeat (5) cycle(1'b0, 1'b0, '0, 1'b1);

        // Alternating back-pressure
        cycle(1'b0, 1'b1, FA, 1'b0);
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, '0, (i % 2) == 0);

        // Fill both banks, drop a third frame, then drain back to back
        cycle(1'b0, 1'b1, FA, 1'b0);
        cycle(1'b0, 1'b1, FB, 1'b0);
        cycle(1'b0, 1'b1, FC, 1'b0);
        cycle(1'b0, 1'b0, '0, 1'b0);
        repeat (9) cycle(1'b0, 1'b0, '0, 1'b1);

        // Reset mid-frame, then a fresh frame
        cycle(1'b0, 1'b1, FA, 1'b1);
        repeat (2) cycle(1'b0, 1'b0, '0, 1'b1);
        cycle(1'b1, 1'b0, '0, 1'b1);
        cycle(1'b0, 1'b1, FB, 1'b1);
        repeat (5) cycle(1'b0, 1'b0, '0, 1'b1);

        // Freeing a bank while upstream holds a frame: capture lands the cycle after
        cycle(1'b0, 1'b1, FA, 1'b0);
        cycle(1'b0, 1'b1, FB, 1'b0);
        repeat (6) cycle(1'b0, 1'b1, FC, 1'b1);
        repeat (6) cycle(1'b0, 1'b0, '0, 1'b1);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 1500; i++) begin
            cycle($urandom_range(0, 99) == 0,
                  $urandom_range(0, 2) == 0,
                  DC*DW'($urandom()),
                  $urandom_range(0, 3) != 0);
        end

        // Sustained one-frame-per-DATA_CNT traffic never overflows
        cycle(1'b1, 1'b0, '0, 1'b1);
        for (int i = 0; i < 40; i++) begin
            cycle(1'b0, (i % DC) == 0, DC*DW'($urandom()), 1'b1);
        end
        check("sustained_no_overflow", 32'(f_overflow | r_overflow), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/order_unloader.md
# order_unloader

Output stage of the ordering datapath, directly downstream of the compare-exchange pipeline. It captures one fully ordered `DATA_CNT`-word vector per frame from the last network stage into a two-bank (ping-pong) buffer. It then streams the words out one per transfer on a valid/ready interface, in forward or reverse index order. While one bank drains, the other accepts the next frame, so back-to-back frames stream without a bubble.

## Interface
- `DATA_WIDTH`, 64: width of one element.
- `DATA_CNT`, 1024: elements per frame. Must be a power of two, ≥ 2.
- `OUT_ORDER`, "FWD": "FWD" emits index 0 first. "REV" emits index `DATA_CNT-1` first.
- `IDX_W`, `$clog2(DATA_CNT)`: index width (derived).

Ports:
- `clk`, in, 1: single clock. All logic is on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `sort_data`, in, `DATA_CNT*DATA_WIDTH`: ordered vector from the network. Element i is at `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `sort_valid`, in, 1: `sort_data` is a complete frame this cycle.
- `sort_ready`, out, 1: a bank is free. Frames are captured only when `sort_valid && sort_ready`.
- `m_data`, out, `DATA_WIDTH`: current output element.
- `m_idx`, out, `IDX_W`: element index of `m_data` within its frame.
- `m_valid`, out, 1: `m_data`, `m_idx` and `m_last` are valid.
- `m_ready`, in, 1: the consumer accepts. A transfer occurs when `m_valid && m_ready`.
- `m_last`, out, 1: the current element is the final element of its frame.
- `busy`, out, 1: at least one bank is full.
- `overflow`, out, 1: sticky. Set when `sort_valid && !sort_ready`; cleared only by `rst`.

## Operation
State:
- `bank[0:1]`: frame storage.
- `full[1:0]`: per-bank occupancy flags.
- `wr_sel`, `rd_sel`: 1-bit bank pointers.
- `cnt`: `IDX_W`-bit transfer counter.
- `overflow` flag.

Capture:
- On `sort_valid && sort_ready`: `bank[wr_sel] <= sort_data`, `full[wr_sel] <= 1`, `wr_sel` toggles.
- `sort_ready = !full[wr_sel]`. This uses registered flags, so there is no combinational path from `m_ready`.

Drain:
- States are IDLE and STREAM. The state is implied by the flags: STREAM ⇔ `full[rd_sel]`.
- `m_valid = full[rd_sel]`.
- `m_idx = cnt` for "FWD", or `DATA_CNT-1-cnt` for "REV".
- `m_data = bank[rd_sel][m_idx]`.
- `m_last = m_valid && (cnt == DATA_CNT-1)`.
- On a transfer: `cnt` increments. If `m_last` is high: `cnt <= 0`, `full[rd_sel] <= 0`, `rd_sel` toggles.
- `busy = |full`.

Boundary conditions:
- Dropped frame: `sort_valid` while `!sort_ready` does not write any bank. The frame is discarded and `overflow` is set.
- Freeing and capturing in the same cycle: freeing bank X while `wr_sel == X` does not allow a capture into X in that cycle, because `sort_ready` was 0. The capture is allowed from the next cycle.
- Capture and transfer in the same cycle: they are independent when they target different banks.
- Stalled transfer: while `m_valid && !m_ready`, `m_data`, `m_idx` and `m_last` hold stable. The bank is not rewritten while full.
- Counter wrap: `cnt` wraps only through the `m_last` path.
- Reset mid-frame: the partially drained frame and any queued frame are discarded.

Reset values:
- `full = 0`, `wr_sel = rd_sel = 0`, `cnt = 0`, `overflow = 0`.
- Hence `sort_ready = 1`, `m_valid = 0`, `m_last = 0`, `busy = 0`.
- `m_idx` = 0 (FWD) or `DATA_CNT-1` (REV).
- `m_data` is don't-care while `m_valid = 0`.
- Bank contents are not reset.

## Timing
- Capture at edge k puts `m_valid = 1` with the first element in the cycle after edge k. Latency is 1 cycle.
- With `m_ready = 1` held, one frame drains in exactly `DATA_CNT` cycles.
- A queued second frame follows in the next cycle with no idle cycle.
- Sustained throughput is one element per cycle. The upstream may present one frame every `DATA_CNT` cycles without overflow.
- `sort_ready` deasserts the cycle after the second bank fills. It reasserts the cycle after the `m_last` transfer.

## Test plan
Scenarios 2–6 use `DATA_WIDTH=8` and `DATA_CNT=4`. The frame A = {0x11, 0x22, 0x33, 0x44} has element 0 = 0x11.

1. Reset, then idle. Required: `sort_ready=1`, `m_valid=0`, `busy=0`, `overflow=0` on every cycle.
2. FWD, capture A, `m_ready=1`. Required: the next 4 cycles show `m_data` 11, 22, 33, 44 with `m_idx` 0–3. `m_last` is high only on 44. `busy` is low the cycle after.
3. FWD, A with `m_ready` pattern 1,0,1,0,… Required: same sequence over 8 cycles. Outputs hold during each stalled cycle.
4. `m_ready=0`, capture A then B = {0x55, 0x66, 0x77, 0x88}, then a third frame. Required: `sort_ready=0` after B is captured. The third frame sets `overflow=1` and is dropped. With `m_ready=1`, output is 11…44 then 55…88 on 8 consecutive cycles with no bubble, and `overflow` stays 1.
5. REV, capture A, `m_ready=1`. Required: `m_data` 44, 33, 22, 11 with `m_idx` 3, 2, 1, 0. `m_last` is high on 11.
6. Capture A, transfer 2 words, then assert `rst` for 1 cycle. Required: next cycle `m_valid=0`, `busy=0`, `sort_ready=1`. A new capture of B then starts at 55 with `m_idx=0`.
